// File: rtl/lsa_reset_sequencer.sv
// Core reset sequencer: holds the core in reset, releases it, and watches its
// heartbeat, retrying a bounded number of times before locking out.
module lsa_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES     = 128,
  parameter int unsigned WATCHDOG_CYCLES = 1048576,
  parameter int unsigned MAX_RESTARTS    = 3,
  parameter bit          AUTO_START      = 1'b1
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_start,
  input  logic       in_stop,
  input  logic       in_activity,
  output logic       out_core_reset,
  output logic       out_running,
  output logic       out_fault,
  output logic [2:0] out_state,
  output logic [7:0] out_restart_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_RETRY   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned WW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(WATCHDOG_CYCLES - 1);
  localparam logic [7:0]    MAX_R     = 8'(MAX_RESTARTS);

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [7:0]    restart_q, restart_d;
  logic          act_prev_q, start_prev_q;
  logic          core_reset_q, running_q, fault_q;
  logic          activity, start_rise;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wd_d       = wd_q;
    restart_d  = restart_q;
    activity   = in_activity ^ act_prev_q;
    start_rise = in_start & ~start_prev_q;
    case (state_q)
      ST_IDLE: begin
        if ((in_start || AUTO_START) && !in_stop) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          restart_d = '0;
        end
      end
      ST_HOLD: begin
        if (in_stop) begin
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
          wd_d    = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_RUN: begin
        // With the watchdog disabled the counter simply parks at all-ones.
        if (in_stop) begin
          state_d = ST_IDLE;
        end else if (activity) begin
          wd_d = '0;
        end else if (WATCHDOG_CYCLES != 0 && wd_q == WD_LAST) begin
          state_d = ST_RETRY;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RETRY: begin
        if (in_stop) begin
          state_d = ST_IDLE;
        end else if (restart_q < MAX_R) begin
          restart_d = (restart_q == 8'hFF) ? restart_q : restart_q + 8'd1;
          state_d   = ST_HOLD;
          hold_d    = '0;
        end else begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        if (start_rise && !in_stop) begin
          state_d   = ST_HOLD;
          hold_d    = '0;
          restart_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so reset drops on the first RUN cycle.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      wd_q         <= '0;
      restart_q    <= '0;
      act_prev_q   <= 1'b0;
      start_prev_q <= 1'b0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      wd_q         <= wd_d;
      restart_q    <= restart_d;
      act_prev_q   <= in_activity;
      start_prev_q <= in_start;
      core_reset_q <= (state_d != ST_RUN);
      running_q    <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_LOCKOUT);
    end
  end

  assign out_core_reset    = core_reset_q;
  assign out_running       = running_q;
  assign out_fault         = fault_q;
  assign out_state         = state_q;
  assign out_restart_count = restart_q;

endmodule

// File: tb/tb_lsa_reset_sequencer.sv
// Bench for lsa_reset_sequencer: a cycle table on a short-hold manual-start
// instance, plus hand sequences for hold length, watchdog, lockout and reset.
module tb_lsa_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: HOLD 128, watchdog 16, two restarts, auto start.
  logic a_rst, a_start, a_stop, a_act;
  logic a_core_reset, a_running, a_fault;
  logic [2:0] a_state;
  logic [7:0] a_count;

  // Instance B: HOLD 3, watchdog off, no restarts, manual start.
  logic b_rst, b_start, b_stop, b_act;
  logic b_core_reset, b_running, b_fault;
  logic [2:0] b_state;
  logic [7:0] b_count;

  lsa_reset_sequencer #(
    .HOLD_CYCLES(128), .WATCHDOG_CYCLES(16), .MAX_RESTARTS(2), .AUTO_START(1'b1)
  ) dut_a (
    .in_clock(clk), .in_reset(a_rst), .in_start(a_start), .in_stop(a_stop),
    .in_activity(a_act), .out_core_reset(a_core_reset), .out_running(a_running),
    .out_fault(a_fault), .out_state(a_state), .out_restart_count(a_count)
  );

  lsa_reset_sequencer #(
    .HOLD_CYCLES(3), .WATCHDOG_CYCLES(0), .MAX_RESTARTS(0), .AUTO_START(1'b0)
  ) dut_b (
    .in_clock(clk), .in_reset(b_rst), .in_start(b_start), .in_stop(b_stop),
    .in_activity(b_act), .out_core_reset(b_core_reset), .out_running(b_running),
    .out_fault(b_fault), .out_state(b_state), .out_restart_count(b_count)
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic [2:0] st;
    logic       crst;
    logic       run;
  } vec_t;

  vec_t vecs[18];
  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic count_in(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (a_state == s && n < budget) begin
      n++;
      tick();
    end
  endtask

  function automatic vec_t mk(input logic st_i, input logic sp_i, input logic [2:0] s,
                              input logic cr, input logic rn);
    vec_t v;
    v.start = st_i; v.stop = sp_i; v.st = s; v.crst = cr; v.run = rn;
    return v;
  endfunction

  initial begin
    int n;
    int bad;

    vecs[0]  = mk(0, 0, 3'd0, 1, 0);
    vecs[1]  = mk(0, 0, 3'd0, 1, 0);
    vecs[2]  = mk(1, 1, 3'd0, 1, 0);
    vecs[3]  = mk(1, 0, 3'd1, 1, 0);
    vecs[4]  = mk(1, 0, 3'd1, 1, 0);
    vecs[5]  = mk(0, 0, 3'd1, 1, 0);
    vecs[6]  = mk(0, 0, 3'd2, 0, 1);
    vecs[7]  = mk(0, 0, 3'd2, 0, 1);
    vecs[8]  = mk(1, 0, 3'd2, 0, 1);
    vecs[9]  = mk(0, 1, 3'd0, 1, 0);
    vecs[10] = mk(0, 1, 3'd0, 1, 0);
    vecs[11] = mk(0, 0, 3'd0, 1, 0);
    vecs[12] = mk(1, 0, 3'd1, 1, 0);
    vecs[13] = mk(0, 1, 3'd0, 1, 0);
    vecs[14] = mk(1, 0, 3'd1, 1, 0);
    vecs[15] = mk(1, 0, 3'd1, 1, 0);
    vecs[16] = mk(1, 0, 3'd1, 1, 0);
    vecs[17] = mk(1, 0, 3'd2, 0, 1);

    a_rst = 1'b1; a_start = 1'b0; a_stop = 1'b0; a_act = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_stop = 1'b0; b_act = 1'b0;
    tick();
    tick();

    chk("a_reset_state", a_state, 0);
    chk("a_reset_core_reset", a_core_reset, 1);
    chk("a_reset_running", a_running, 0);
    chk("a_reset_fault", a_fault, 0);
    chk("a_reset_count", a_count, 0);

    // Table on instance B, one vector per clock.
    b_rst = 1'b0;
    chk("b_idle_after_reset", b_state, 0);
    for (int i = 0; i < 18; i++) begin
      b_start = vecs[i].start;
      b_stop  = vecs[i].stop;
      tick();
      $display("vec %0d start=%b stop=%b state=%0d core_reset=%b running=%b",
               i, b_start, b_stop, b_state, b_core_reset, b_running);
      chk($sformatf("vec%0d_state", i), b_state, vecs[i].st);
      chk($sformatf("vec%0d_core_reset", i), b_core_reset, vecs[i].crst);
      chk($sformatf("vec%0d_running", i), b_running, vecs[i].run);
    end
    b_start = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (b_state != 3'd2) bad++;
    end
    $display("b watchdog-disabled run: %0d non-RUN cycles", bad);
    chk("b_wd_disabled_nonrun", bad, 0);
    chk("b_fault", b_fault, 0);
    chk("b_count", b_count, 0);

    // Instance A: power-up sequence.
    a_rst = 1'b0;
    chk("a_idle_after_release", a_state, 0);
    tick();
    chk("a_enter_hold", a_state, 1);
    count_in(3'd1, 300, n);
    $display("a first hold: %0d cycles", n);
    chk("a_hold_len", n, 128);
    chk("a_run_state", a_state, 2);
    chk("a_run_core_reset", a_core_reset, 0);
    chk("a_run_running", a_running, 1);

    // Heartbeat every 10 cycles keeps it running.
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (a_state != 3'd2) bad++;
      if (c % 10 == 9) a_act = ~a_act;
      tick();
    end
    $display("a heartbeat run: %0d non-RUN cycles", bad);
    chk("a_heartbeat_nonrun", bad, 0);
    chk("a_heartbeat_count", a_count, 0);

    // Stuck heartbeat: two retries, then lockout.
    count_in(3'd2, 40, n);
    chk("a_retry1_state", a_state, 3);
    chk("a_retry1_count", a_count, 0);
    tick();
    chk("a_retry1_hold", a_state, 1);
    chk("a_retry1_count_after", a_count, 1);
    count_in(3'd1, 300, n);
    chk("a_retry1_hold_len", n, 128);
    count_in(3'd2, 100, n);
    $display("a run before expiry: %0d cycles", n);
    chk("a_wd_run_len", n, 16);
    chk("a_retry2_state", a_state, 3);
    tick();
    chk("a_retry2_hold", a_state, 1);
    chk("a_retry2_count", a_count, 2);
    count_in(3'd1, 300, n);
    chk("a_retry2_hold_len", n, 128);
    count_in(3'd2, 100, n);
    chk("a_wd_run_len2", n, 16);
    chk("a_retry3_state", a_state, 3);
    tick();
    $display("a lockout: state=%0d fault=%b count=%0d", a_state, a_fault, a_count);
    chk("a_lockout_state", a_state, 4);
    chk("a_lockout_fault", a_fault, 1);
    chk("a_lockout_core_reset", a_core_reset, 1);
    chk("a_lockout_running", a_running, 0);
    chk("a_lockout_count", a_count, 2);
    repeat (5) tick();
    chk("a_lockout_holds", a_state, 4);

    // Start pulse exits lockout.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    $display("a start pulse: state=%0d fault=%b count=%0d", a_state, a_fault, a_count);
    chk("a_unlock_state", a_state, 1);
    chk("a_unlock_count", a_count, 0);
    chk("a_unlock_fault", a_fault, 0);
    count_in(3'd1, 300, n);
    chk("a_unlock_hold_len", n, 128);
    chk("a_unlock_run", a_state, 2);

    // Stop and start together in RUN: stop wins.
    a_start = 1'b1;
    a_stop  = 1'b1;
    tick();
    $display("a stop+start: state=%0d core_reset=%b", a_state, a_core_reset);
    chk("a_stop_state", a_state, 0);
    chk("a_stop_core_reset", a_core_reset, 1);
    chk("a_stop_running", a_running, 0);
    a_start = 1'b0;
    repeat (3) tick();
    chk("a_stop_held_idle", a_state, 0);
    a_stop = 1'b0;
    tick();
    chk("a_stop_release_hold", a_state, 1);

    // Asynchronous reset at hold count 50.
    repeat (50) tick();
    chk("a_mid_hold", a_state, 1);
    #2 a_rst = 1'b1;
    #1;
    $display("a async reset: state=%0d core_reset=%b", a_state, a_core_reset);
    chk("a_async_state", a_state, 0);
    chk("a_async_core_reset", a_core_reset, 1);
    chk("a_async_running", a_running, 0);
    chk("a_async_count", a_count, 0);
    tick();
    a_rst = 1'b0;
    chk("a_post_reset_idle", a_state, 0);
    tick();
    chk("a_post_reset_hold", a_state, 1);
    count_in(3'd1, 300, n);
    $display("a hold after reset: %0d cycles", n);
    chk("a_post_reset_hold_len", n, 128);
    chk("a_post_reset_run", a_state, 2);
    chk("a_post_reset_core_reset", a_core_reset, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
